// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage enable/flush, PC-select and exception strobes for a 3-stage core,
// plus a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_taken_i,
  input  logic                 ld_use_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  input  logic                 irq_i,
  input  logic                 irq_en_i,
  input  logic                 cnt_clr_i,
  output logic                 pc_en_o,
  output logic                 ifde_en_o,
  output logic                 ifde_flush_o,
  output logic                 demw_en_o,
  output logic                 demw_flush_o,
  output logic [1:0]           pc_sel_o,
  output logic                 epc_we_o,
  output logic                 irq_ack_o,
  output logic                 mem_err_o,
  output logic [BUS_WIDTH-1:0] stall_cnt_o
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [TW-1:0] TMO_PENULT = TW'(MEM_TIMEOUT - 1);
  localparam logic [FW-1:0] REM_INIT   = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] REM_ONE    = FW'(1);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_IRQ = 2'b10;
  localparam logic [1:0] SEL_ERR = 2'b11;

  typedef enum logic [2:0] {
    S_RUN,
    S_LD_BUBBLE,
    S_MEM_WAIT,
    S_FLUSH,
    S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic [FW-1:0] rem, rem_nxt;
  logic          mem_stall;

  assign mem_stall = mem_req_i & ~mem_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      tmo   <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      tmo   <= tmo_nxt;
      rem   <= rem_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    tmo_nxt      = tmo;
    rem_nxt      = rem;
    pc_en_o      = 1'b1;
    ifde_en_o    = 1'b1;
    demw_en_o    = 1'b1;
    ifde_flush_o = 1'b0;
    demw_flush_o = 1'b0;
    pc_sel_o     = SEL_SEQ;
    epc_we_o     = 1'b0;
    irq_ack_o    = 1'b0;
    mem_err_o    = 1'b0;

    if (state != S_MEM_WAIT && state != S_ERR && mem_stall) begin
      // A stalled memory access freezes the whole pipe and drops any flush still pending.
      pc_en_o   = 1'b0;
      ifde_en_o = 1'b0;
      demw_en_o = 1'b0;
      tmo_nxt   = TMO_ONE;
      if (MEM_TIMEOUT == 1) begin
        mem_err_o = 1'b1;
        state_nxt = S_ERR;
      end else begin
        state_nxt = S_MEM_WAIT;
      end
    end else begin
      case (state)
        S_RUN, S_LD_BUBBLE: begin
          state_nxt = S_RUN;
          if (br_taken_i) begin
            pc_sel_o     = SEL_BR;
            ifde_flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = S_FLUSH;
              rem_nxt   = REM_INIT;
            end
          end else if (ld_use_i && state == S_RUN) begin
            pc_en_o      = 1'b0;
            ifde_en_o    = 1'b0;
            demw_flush_o = 1'b1;
            state_nxt    = S_LD_BUBBLE;
          end else if (irq_i && irq_en_i) begin
            pc_sel_o     = SEL_IRQ;
            ifde_flush_o = 1'b1;
            epc_we_o     = 1'b1;
            irq_ack_o    = 1'b1;
          end
        end

        S_MEM_WAIT: begin
          if (mem_ready_i) begin
            state_nxt = S_RUN;
          end else begin
            pc_en_o   = 1'b0;
            ifde_en_o = 1'b0;
            demw_en_o = 1'b0;
            tmo_nxt   = tmo + TW'(1);
            if (tmo == TMO_PENULT) begin
              mem_err_o = 1'b1;
              state_nxt = S_ERR;
            end
          end
        end

        S_FLUSH: begin
          ifde_flush_o = 1'b1;
          if (br_taken_i) begin
            pc_sel_o = SEL_BR;
            rem_nxt  = REM_INIT;
          end else begin
            rem_nxt = rem - REM_ONE;
            if (rem == REM_ONE) state_nxt = S_RUN;
          end
        end

        S_ERR: begin
          pc_sel_o     = SEL_ERR;
          ifde_flush_o = 1'b1;
          demw_flush_o = 1'b1;
          state_nxt    = S_RUN;
        end

        default: state_nxt = S_RUN;
      endcase
    end

    // Outputs follow reset immediately, not at the next edge.
    if (!rst) begin
      pc_en_o      = 1'b0;
      ifde_en_o    = 1'b0;
      demw_en_o    = 1'b0;
      ifde_flush_o = 1'b1;
      demw_flush_o = 1'b1;
      pc_sel_o     = SEL_SEQ;
      epc_we_o     = 1'b0;
      irq_ack_o    = 1'b0;
      mem_err_o    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o <= '0;
    end else if (!pc_en_o && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + BUS_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a history-based reference model queues the expected
// outputs per cycle and a separate monitor compares them against the DUT.
module tb_pipeline_ctrl;

  localparam int BW = 4;
  localparam int FC = 2;
  localparam int MT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          br_taken_i = 1'b0, ld_use_i = 1'b0, mem_req_i = 1'b0, mem_ready_i = 1'b0;
  logic          irq_i = 1'b0, irq_en_i = 1'b0, cnt_clr_i = 1'b0;
  logic          pc_en_o, ifde_en_o, ifde_flush_o, demw_en_o, demw_flush_o;
  logic [1:0]    pc_sel_o;
  logic          epc_we_o, irq_ack_o, mem_err_o;
  logic [BW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .BUS_WIDTH   (BW),
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .br_taken_i  (br_taken_i),
    .ld_use_i    (ld_use_i),
    .mem_req_i   (mem_req_i),
    .mem_ready_i (mem_ready_i),
    .irq_i       (irq_i),
    .irq_en_i    (irq_en_i),
    .cnt_clr_i   (cnt_clr_i),
    .pc_en_o     (pc_en_o),
    .ifde_en_o   (ifde_en_o),
    .ifde_flush_o(ifde_flush_o),
    .demw_en_o   (demw_en_o),
    .demw_flush_o(demw_flush_o),
    .pc_sel_o    (pc_sel_o),
    .epc_we_o    (epc_we_o),
    .irq_ack_o   (irq_ack_o),
    .mem_err_o   (mem_err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct packed {
    logic [9:0]    ctrl;  // pc_en, ifde_en, ifde_flush, demw_en, demw_flush, pc_sel[1:0], epc_we, irq_ack, mem_err
    logic [BW-1:0] stall;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model history: length of the current memory wait, remaining flush cycles,
  // whether the previous cycle was an error trap or a load-use bubble, and stall cycles seen.
  int m_wait  = 0;
  int m_flush = 0;
  int m_stall = 0;
  bit m_err   = 1'b0;
  bit m_bub   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  task automatic step(input logic r, input logic br, input logic ld, input logic req,
                      input logic rdy, input logic irq, input logic ien, input logic clr);
    logic pe, ie, ifl, de, dfl, epc, ack, err;
    logic [1:0] sel;
    bit was_bub;
    exp_t e;
    pe = 1'b1; ie = 1'b1; de = 1'b1; ifl = 1'b0; dfl = 1'b0;
    sel = 2'd0; epc = 1'b0; ack = 1'b0; err = 1'b0;
    e = '0;
    if (!r) begin
      pe = 1'b0; ie = 1'b0; de = 1'b0; ifl = 1'b1; dfl = 1'b1;
      m_wait = 0; m_flush = 0; m_err = 1'b0; m_bub = 1'b0; m_stall = 0;
      e.stall = '0;
    end else begin
      e.stall = m_stall[BW-1:0];
      was_bub = m_bub;
      m_bub = 1'b0;
      if (m_err) begin
        sel = 2'd3; ifl = 1'b1; dfl = 1'b1;
        m_err = 1'b0;
      end else if (m_wait > 0) begin
        if (rdy) begin
          m_wait = 0;
        end else begin
          pe = 1'b0; ie = 1'b0; de = 1'b0;
          m_wait++;
          if (m_wait == MT) begin
            err = 1'b1; m_err = 1'b1; m_wait = 0;
          end
        end
      end else if (req && !rdy) begin
        pe = 1'b0; ie = 1'b0; de = 1'b0;
        m_flush = 0; m_wait = 1;
      end else if (br) begin
        sel = 2'd1; ifl = 1'b1;
        m_flush = FC - 1;
      end else if (m_flush > 0) begin
        ifl = 1'b1;
        m_flush--;
      end else if (ld && !was_bub) begin
        pe = 1'b0; ie = 1'b0; dfl = 1'b1;
        m_bub = 1'b1;
      end else if (irq && ien) begin
        sel = 2'd2; ifl = 1'b1; epc = 1'b1; ack = 1'b1;
      end
      if (clr) m_stall = 0;
      else if (!pe && m_stall < (2 ** BW) - 1) m_stall++;
    end
    e.ctrl = {pe, ie, ifl, de, dfl, sel, epc, ack, err};
    sb_q.push_back(e);

    rst = r; br_taken_i = br; ld_use_i = ld; mem_req_i = req; mem_ready_i = rdy;
    irq_i = irq; irq_en_i = ien; cnt_clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle away from the clock edge.
  initial begin
    exp_t want;
    logic [9:0] got_ctrl;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        want = sb_q.pop_front();
        got_ctrl = {pc_en_o, ifde_en_o, ifde_flush_o, demw_en_o, demw_flush_o,
                    pc_sel_o, epc_we_o, irq_ack_o, mem_err_o};
        check("ctrl", 32'(got_ctrl), 32'(want.ctrl));
        check("stall_cnt", 32'(stall_cnt_o), 32'(want.stall));
        cyc++;
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Held load-use hazard yields exactly one bubble.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    idle(2);

    // Memory ready after three wait cycles.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    idle(2);

    // Memory never ready: timeout pulse then error vector.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    idle(2);

    // Branch, load-use and interrupt together, then interrupt held.
    step(1, 1, 1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    idle(2);

    // Reset in the middle of a memory wait, then release.
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Drive the 4-bit stall counter into saturation, then clear it.
    for (int i = 0; i < 40; i++) step(1, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    idle(2);

    // Branch arriving inside a flush window restarts it.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 59) != 0),
           logic'($urandom_range(0, 5) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 1) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 1) == 0),
           logic'($urandom_range(0, 19) == 0));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
